// File: rtl/cache.sv
// Direct-mapped write-allocate cache holding valid/tag/data per line and reporting hit/miss.
// One-cycle read latency; no backpressure: an access is accepted on every clock with chipSel=1.
module cache #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipSel,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] dat,
  input  logic              write,
  output logic              miss
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic              miss_q, miss_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               wr_en;
  logic               rd_drive;

  assign idx   = addr[INDEX_W-1:0];
  assign tag   = addr[ADDR_W-1:INDEX_W];
  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign wr_en = chipSel && write && !reset;

  // Hit is judged against the pre-write contents, so a write reports miss before allocating.
  always_comb begin
    miss_d  = 1'b0;
    rdata_d = rdata_q;
    if (chipSel) begin
      miss_d = ~hit;
      if (!write) begin
        rdata_d = hit ? data_q[idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      miss_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      miss_q  <= miss_d;
      rdata_q <= rdata_d;
      if (wr_en) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= dat;
    end
  end

  assign rd_drive = chipSel && !write && !reset;
  assign dat      = rd_drive ? rdata_q : {DATA_W{1'bz}};
  assign miss     = miss_q;

endmodule

// File: tb/tb_cache.sv
// Directed and randomized checks of cache against a line-map reference model.
module tb_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipSel;
  logic [7:0]  addr;
  logic        write;
  logic        miss;
  wire  [31:0] dat;

  logic        tb_oe;
  logic [31:0] tb_wdata;

  localparam logic [31:0] IDLE_PAT = 32'hDEAD_BEEF;

  int tests = 0;
  int fails = 0;

  // Reference model: each line remembers the full word address it holds.
  bit          m_valid [32];
  logic [7:0]  m_addr  [32];
  logic [31:0] m_data  [32];
  logic [31:0] m_rd;

  assign dat = tb_oe ? tb_wdata : 32'bz;

  always #5 clk = ~clk;

  cache dut (
    .clk     (clk),
    .reset   (reset),
    .chipSel (chipSel),
    .addr    (addr),
    .dat     (dat),
    .write   (write),
    .miss    (miss)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [7:0] a);
    return m_valid[a % 32] && (m_addr[a % 32] == a);
  endfunction

  // Called at a negedge: apply one access, let the edge take it, check at the next negedge.
  task automatic step(input bit rst, input bit cs, input bit wr, input logic [7:0] a,
                      input logic [31:0] d, input string name);
    logic        exp_miss;
    logic [31:0] exp_rd;
    logic [31:0] bus_val;
    bit          dut_drives;
    if (rst) begin
      exp_miss = 1'b0;
      exp_rd   = 32'd0;
    end else if (!cs) begin
      exp_miss = 1'b0;
      exp_rd   = m_rd;
    end else begin
      exp_miss = !m_hit(a);
      exp_rd   = wr ? m_rd : (m_hit(a) ? m_data[a % 32] : 32'd0);
    end
    dut_drives = cs && !wr && !rst;
    bus_val    = (cs && wr) ? d : IDLE_PAT;
    reset    = rst;
    chipSel  = cs;
    write    = wr;
    addr     = a;
    tb_wdata = bus_val;
    tb_oe    = !dut_drives;
    @(posedge clk);
    @(negedge clk);
    chk({name, ".miss"}, {31'd0, miss}, {31'd0, exp_miss});
    if (dut_drives) chk({name, ".dat"}, dat, exp_rd);
    else            chk({name, ".bus"}, dat, bus_val);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    end else if (cs && wr) begin
      m_valid[a % 32] = 1'b1;
      m_addr[a % 32]  = a;
      m_data[a % 32]  = d;
    end
    m_rd = exp_rd;
  endtask

  // Show the held read-data register combinationally without clocking an access.
  task automatic peek(input string name);
    reset   = 1'b0;
    chipSel = 1'b1;
    write   = 1'b0;
    tb_oe   = 1'b0;
    #1;
    chk(name, dat, m_rd);
  endtask

  initial begin
    bit          r_rst, r_cs, r_wr;
    logic [7:0]  r_a;
    logic [31:0] r_d;
    reset    = 1'b1;
    chipSel  = 1'b0;
    write    = 1'b0;
    addr     = 8'd0;
    tb_oe    = 1'b1;
    tb_wdata = IDLE_PAT;
    m_rd     = 32'd0;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = 8'd0;
      m_data[i]  = 32'd0;
    end
    @(negedge clk);
    step(1, 0, 0, 8'd0, 32'd0, "reset");
    peek("reset_rd");

    step(0, 1, 0, 8'd1,  32'd0,  "cold_rd1");
    step(0, 1, 1, 8'd1,  32'd15, "wr1");
    step(0, 1, 1, 8'd2,  32'd14, "wr2");
    step(0, 1, 0, 8'd1,  32'd0,  "rd1");
    step(0, 1, 0, 8'd1,  32'd0,  "rd1_again");
    step(0, 1, 0, 8'd2,  32'd0,  "rd2");
    step(0, 1, 0, 8'd34, 32'd0,  "alias_rd34");
    step(0, 1, 1, 8'd34, 32'd99, "wr34");
    step(0, 1, 0, 8'd34, 32'd0,  "rd34");
    step(0, 1, 0, 8'd2,  32'd0,  "rd2_evicted");
    step(0, 1, 1, 8'd5,  32'd7,  "wr5a");
    step(0, 1, 1, 8'd5,  32'd8,  "wr5b");
    step(0, 1, 0, 8'd5,  32'd0,  "rd5");
    step(0, 0, 0, 8'd1,  32'd0,  "idle");
    peek("idle_rd_held");
    step(0, 1, 0, 8'd1,  32'd0,  "rd1_after_idle");
    step(0, 1, 1, 8'd0,   32'h0000_0A0A, "wr0");
    step(0, 1, 1, 8'd255, 32'hFFFF_0001, "wr255");
    step(0, 1, 0, 8'd0,   32'd0, "rd0");
    step(0, 1, 0, 8'd255, 32'd0, "rd255");
    step(1, 1, 1, 8'd3,  32'd77, "reset_wr3");
    peek("reset_rd_clr");
    step(0, 1, 0, 8'd1,  32'd0,  "rd1_post_reset");
    step(0, 1, 0, 8'd3,  32'd0,  "rd3_post_reset");
    step(1, 1, 0, 8'd1,  32'd0,  "reset_rd");

    // Random traffic on few indices so aliasing and rewrite hits are frequent.
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 49) == 0);
      r_cs  = ($urandom_range(0, 7) != 0);
      r_wr  = $urandom_range(0, 1) == 1;
      r_a   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                           : {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3))};
      r_d   = $urandom;
      step(r_rst, r_cs, r_wr, r_a, r_d, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache.md
Name: cache

Overview:
- Direct-mapped, write-allocate data cache: 256-word byte-free address space (8-bit word address), 32-bit words, 32 lines.
- Sits between the pipeline memory stage and backing memory. This block holds tag/valid/data storage only and reports hit or miss.
- Refill from backing memory is done by the caller, which issues a write to the missed address.
- Single shared bidirectional data bus: the caller drives it for writes, the cache drives it for reads.

Parameters:
- ADDR_W, 8, word address width.
- DATA_W, 32, data word width.
- INDEX_W, 5, line index width; lines = 2**INDEX_W; tag width = ADDR_W-INDEX_W (3).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- chipSel  input  1  cache access enable; no access and bus released when 0.
- addr  input  ADDR_W  word address; index = addr[INDEX_W-1:0], tag = addr[ADDR_W-1:INDEX_W].
- dat  inout  DATA_W  data bus. Driven by cache only when chipSel=1 and write=0, otherwise high-Z. Sampled as write data when chipSel=1 and write=1.
- write  input  1  1 = write access, 0 = read access.
- miss  output  1  registered miss flag for the most recent access.

Behaviour:
- Storage per line: valid bit, tag[ADDR_W-INDEX_W-1:0], data[DATA_W-1:0].
- Reset, on a rising clk edge with reset=1:
  - all valid bits cleared;
  - miss <= 0;
  - read-data register <= 0.
  - Tag and data arrays need not be cleared.
  - Reset overrides any access in the same cycle.
- Hit condition, combinational: valid[index] && tag[index]==addr tag.
- Read (chipSel=1, write=0) at rising edge:
  - miss <= ~hit;
  - read-data register <= hit ? data[index] : 0.
  - No array state changes.
- Write (chipSel=1, write=1) at rising edge:
  - miss <= ~hit, evaluated against the state before the write;
  - data[index] <= dat, tag[index] <= addr tag, valid[index] <= 1.
  - Write-allocate; any prior occupant is overwritten with no writeback.
  - Read-data register unchanged.
- Idle (chipSel=0) at rising edge: miss <= 0; arrays and read-data register unchanged.
- Read latency: 1 cycle. Address is sampled at the edge; dat and miss reflect that access from just after the edge until the next edge.
- Bus drive:
  - dat = read-data register whenever chipSel=1 and write=0, combinational enable;
  - high-Z otherwise, including during reset.
  - No contention with the write driver is permitted.
- Aliasing: addresses that differ only in tag bits (e.g. 2 and 34, 1 and 33) share a line. An access to one after the other has been allocated misses.
- Back-to-back accesses every cycle are supported; a read immediately after a write to the same address hits and returns the new data.
- Address 0 and 255 are ordinary addresses (index 0/tag 0, index 31/tag 7).

Test Plan:
- Reset then read addr 1 -> miss=1, dat=0 after edge.
- Write 15 to addr 1 (cold), then write 14 to addr 2 -> miss=1 on each write cycle. Then read addr 1 -> dat=15, miss=0; read addr 1 again -> 15, miss=0; read addr 2 -> 14, miss=0.
- After the above, read addr 34 (same index as 2, tag 1) -> miss=1, dat=0. Then write 99 to addr 34 -> read addr 34 gives 99/miss=0, read addr 2 gives miss=1.
- Write 7 to addr 5, then write 8 to addr 5 -> second write miss=0; read addr 5 -> 8.
- chipSel=0 with write=0 -> dat high-Z, miss=0, arrays intact. A later read of addr 1 still returns 15.
- Reset asserted mid-sequence, together with a write to addr 3 -> write ignored. Subsequent reads of addr 1 and addr 3 -> miss=1, dat=0.
